// File: rtl/writeback_queue_pkg.sv
// Shared writeback types: one buffered retirement record per entry.
package writeback_queue_pkg;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  writereg;
        logic [31:0] result;
        logic [1:0]  hilo_wen;   // {wen_h, wen_l}
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
    } wb_entry_t;

    function automatic logic has_hilo(input wb_entry_t e);
        return |e.hilo_wen;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer lanes, regfile/hilo drain, retirement trace, forwarding lookup.
interface writeback_queue_if #(
    parameter int LANES  = 2,
    parameter int WPORTS = 2,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0]      in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_regwrite;
    logic [5*LANES-1:0]    in_writereg;
    logic [32*LANES-1:0]   in_result;
    logic [2*LANES-1:0]    in_hilo_wen;
    logic [32*LANES-1:0]   in_hi;
    logic [32*LANES-1:0]   in_lo;
    logic [32*LANES-1:0]   in_pc;

    logic [WPORTS-1:0]     rf_wen;
    logic [5*WPORTS-1:0]   rf_waddr;
    logic [32*WPORTS-1:0]  rf_wdata;
    logic                  hilo_wen_h;
    logic                  hilo_wen_l;
    logic [31:0]           hilo_wd_h;
    logic [31:0]           hilo_wd_l;
    logic [WPORTS-1:0]     commit_valid;
    logic [32*WPORTS-1:0]  commit_pc;

    logic [9:0]            fwd_addr;
    logic [1:0]            fwd_hit;
    logic [63:0]           fwd_data;

    logic [CW-1:0]         count;
    logic                  empty;

    modport master (
        output in_valid, in_regwrite, in_writereg, in_result, in_hilo_wen, in_hi, in_lo, in_pc, fwd_addr,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, hilo_wen_h, hilo_wen_l, hilo_wd_h, hilo_wd_l,
               commit_valid, commit_pc, fwd_hit, fwd_data, count, empty
    );

    modport slave (
        input  in_valid, in_regwrite, in_writereg, in_result, in_hilo_wen, in_hi, in_lo, in_pc, fwd_addr,
        output in_ready, rf_wen, rf_waddr, rf_wdata, hilo_wen_h, hilo_wen_l, hilo_wd_h, hilo_wd_l,
               commit_valid, commit_pc, fwd_hit, fwd_data, count, empty
    );
endinterface

// File: rtl/writeback_fwd_cam.sv
// Youngest-match register lookup over the resident queue entries, scanned oldest to youngest.
module writeback_fwd_cam #(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [PW-1:0]            head,
    input  logic [DEPTH-1:0]         writes,
    input  logic [DEPTH-1:0][4:0]    tags,
    input  logic [DEPTH-1:0][31:0]   values,
    input  logic [4:0]               addr,
    output logic                     hit,
    output logic [31:0]              data
);
    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            // later matches in age order overwrite earlier ones, leaving the youngest
            if (writes[idx] && tags[idx] == addr && addr != 5'd0) begin
                hit  = 1'b1;
                data = values[idx];
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// Multi-lane writeback buffer: compacting enqueue, in-order multi-port drain, forwarding lookup.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int WPORTS = 2
) (
    input  logic               clk,
    input  logic               resetn,
    writeback_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [CW-1:0]               count;
    logic [DEPTH-1:0]            resident;
    wb_entry_t [DEPTH-1:0]       mem;

    wb_entry_t [LANES-1:0]       lane_e;
    logic [LANES-1:0]            enq_we;
    logic [LANES-1:0][PW-1:0]    enq_slot;
    logic [CW-1:0]               n_enq;
    logic [DEPTH-1:0]            enq_mask;

    wb_entry_t [WPORTS-1:0]      port_e;
    logic [WPORTS-1:0]           drain;
    logic [CW-1:0]               n_drain;
    logic [DEPTH-1:0]            drain_mask;
    logic                        hilo_taken;
    logic                        stop;

    logic [DEPTH-1:0]            cam_writes;
    logic [DEPTH-1:0][4:0]       cam_tags;
    logic [DEPTH-1:0][31:0]      cam_values;
    logic [1:0]                  fwd_hit_v;
    logic [1:0][31:0]            fwd_data_v;

    assign bus.in_ready = (32'(count) + 32'(LANES)) <= 32'(DEPTH);
    assign bus.count    = count;
    assign bus.empty    = (count == '0);

    always_comb begin
        lane_e = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_e[l].regwrite = bus.in_regwrite[l];
            lane_e[l].writereg = bus.in_writereg[5*l +: 5];
            lane_e[l].result   = bus.in_result[32*l +: 32];
            lane_e[l].hilo_wen = bus.in_hilo_wen[2*l +: 2];
            lane_e[l].hi       = bus.in_hi[32*l +: 32];
            lane_e[l].lo       = bus.in_lo[32*l +: 32];
            lane_e[l].pc       = bus.in_pc[32*l +: 32];
        end
    end

    // valid lanes are packed into consecutive slots starting at tail
    always_comb begin
        enq_we   = '0;
        enq_slot = '0;
        enq_mask = '0;
        n_enq    = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (bus.in_ready && bus.in_valid[l]) begin
                enq_we[l]             = 1'b1;
                enq_slot[l]           = tail + PW'(n_enq);
                enq_mask[enq_slot[l]] = 1'b1;
                n_enq                 = n_enq + CW'(1);
            end
        end
    end

    // drain stops at the first unoccupied port or at a second hilo writer
    always_comb begin
        port_e     = '0;
        drain      = '0;
        drain_mask = '0;
        n_drain    = '0;
        hilo_taken = 1'b0;
        stop       = 1'b0;
        for (int unsigned p = 0; p < WPORTS; p++) begin
            port_e[p] = mem[head + PW'(p)];
            if (stop || p >= 32'(count)) begin
                stop = 1'b1;
            end else if (has_hilo(port_e[p]) && hilo_taken) begin
                stop = 1'b1;
            end else begin
                drain[p]                     = 1'b1;
                drain_mask[head + PW'(p)]    = 1'b1;
                n_drain                      = n_drain + CW'(1);
                hilo_taken                   = hilo_taken | has_hilo(port_e[p]);
            end
        end
    end

    always_comb begin
        bus.rf_wen       = '0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        bus.commit_valid = '0;
        bus.commit_pc    = '0;
        bus.hilo_wen_h   = 1'b0;
        bus.hilo_wen_l   = 1'b0;
        bus.hilo_wd_h    = '0;
        bus.hilo_wd_l    = '0;
        for (int unsigned p = 0; p < WPORTS; p++) begin
            if (drain[p]) begin
                bus.commit_valid[p]        = 1'b1;
                bus.commit_pc[32*p +: 32]  = port_e[p].pc;
                bus.rf_waddr[5*p +: 5]     = port_e[p].writereg;
                bus.rf_wdata[32*p +: 32]   = port_e[p].result;
                bus.rf_wen[p] = port_e[p].regwrite && port_e[p].writereg != 5'd0;
                // a younger write to the same register in this drain group wins
                for (int unsigned q = p + 1; q < WPORTS; q++) begin
                    if (drain[q] && port_e[q].regwrite && port_e[q].writereg == port_e[p].writereg)
                        bus.rf_wen[p] = 1'b0;
                end
                if (has_hilo(port_e[p])) begin
                    bus.hilo_wen_h = port_e[p].hilo_wen[1];
                    bus.hilo_wen_l = port_e[p].hilo_wen[0];
                    bus.hilo_wd_h  = port_e[p].hi;
                    bus.hilo_wd_l  = port_e[p].lo;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            resident <= '0;
        end else begin
            head     <= head + PW'(n_drain);
            tail     <= tail + PW'(n_enq);
            count    <= count + n_enq - n_drain;
            resident <= (resident & ~drain_mask) | enq_mask;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (enq_we[l])
                mem[enq_slot[l]] <= lane_e[l];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cam_writes[i] = resident[i] && mem[i].regwrite;
            cam_tags[i]   = mem[i].writereg;
            cam_values[i] = mem[i].result;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        writeback_fwd_cam #(.DEPTH(DEPTH)) u_cam (
            .head   (head),
            .writes (cam_writes),
            .tags   (cam_tags),
            .values (cam_values),
            .addr   (bus.fwd_addr[5*i +: 5]),
            .hit    (fwd_hit_v[i]),
            .data   (fwd_data_v[i])
        );
    end

    assign bus.fwd_hit  = fwd_hit_v;
    assign bus.fwd_data = {fwd_data_v[1], fwd_data_v[0]};
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: driver queues expected entries, negedge monitor checks drains.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int WPORTS = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if #(.LANES(LANES), .WPORTS(WPORTS), .DEPTH(DEPTH)) bus();

    writeback_queue #(.LANES(LANES), .DEPTH(DEPTH), .WPORTS(WPORTS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    wb_entry_t        drv_e [LANES];
    logic [LANES-1:0] drv_v = '0;
    logic [9:0]       drv_fwd = '0;
    wb_entry_t        sb [$];
    bit               model_ready = 1'b1;
    bit               mon_en = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;
    int unsigned      pc_ctr = 32'h1000;

    always_comb begin
        bus.in_valid = drv_v;
        bus.fwd_addr = drv_fwd;
        for (int l = 0; l < LANES; l++) begin
            bus.in_regwrite[l]         = drv_e[l].regwrite;
            bus.in_writereg[5*l +: 5]  = drv_e[l].writereg;
            bus.in_result[32*l +: 32]  = drv_e[l].result;
            bus.in_hilo_wen[2*l +: 2]  = drv_e[l].hilo_wen;
            bus.in_hi[32*l +: 32]      = drv_e[l].hi;
            bus.in_lo[32*l +: 32]      = drv_e[l].lo;
            bus.in_pc[32*l +: 32]      = drv_e[l].pc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wb_entry_t mk(input bit rw, input int unsigned rno, input int unsigned res,
                                     input int unsigned hw, input int unsigned hi, input int unsigned lo);
        wb_entry_t e;
        e.regwrite = rw;
        e.writereg = 5'(rno);
        e.result   = res;
        e.hilo_wen = 2'(hw);
        e.hi       = hi;
        e.lo       = lo;
        e.pc       = pc_ctr;
        pc_ctr     = pc_ctr + 4;
        return e;
    endfunction

    function automatic wb_entry_t rand_entry();
        int unsigned hw;
        hw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom, hw, $urandom, $urandom);
    endfunction

    // Reference: the queue front drains up to WPORTS entries, at most one of them touching hi/lo.
    task automatic check_cycle();
        int  resident;
        int  nd;
        bit  hseen;
        bit  stop;
        logic        eh, el;
        logic [31:0] ehi, elo;
        resident = sb.size();
        nd = 0; hseen = 0; stop = 0;
        eh = 0; el = 0; ehi = 0; elo = 0;
        check("count", 32'(bus.count), resident);
        check("empty", 32'(bus.empty), 32'(resident == 0));
        check("in_ready", 32'(bus.in_ready), 32'(DEPTH - resident >= LANES));
        model_ready = (DEPTH - resident >= LANES);
        for (int p = 0; p < WPORTS; p++) begin
            if (!stop) begin
                if (p >= resident) stop = 1;
                else if (has_hilo(sb[p]) && hseen) stop = 1;
                else begin
                    nd++;
                    if (has_hilo(sb[p])) begin
                        hseen = 1;
                        eh = sb[p].hilo_wen[1]; el = sb[p].hilo_wen[0];
                        ehi = sb[p].hi; elo = sb[p].lo;
                    end
                end
            end
        end
        for (int p = 0; p < WPORTS; p++) begin
            bit ow;
            bit ewen;
            ow = 0;
            for (int q = p + 1; q < nd; q++)
                if (sb[q].regwrite && sb[q].writereg == sb[p].writereg) ow = 1;
            ewen = (p < nd) && sb[p].regwrite && sb[p].writereg != 0 && !ow;
            check($sformatf("commit_valid[%0d]", p), 32'(bus.commit_valid[p]), 32'(p < nd));
            check($sformatf("commit_pc[%0d]", p), bus.commit_pc[32*p +: 32], (p < nd) ? sb[p].pc : 0);
            check($sformatf("rf_wen[%0d]", p), 32'(bus.rf_wen[p]), 32'(ewen));
            if (ewen || p >= nd) begin
                check($sformatf("rf_waddr[%0d]", p), 32'(bus.rf_waddr[5*p +: 5]), ewen ? 32'(sb[p].writereg) : 0);
                check($sformatf("rf_wdata[%0d]", p), bus.rf_wdata[32*p +: 32], ewen ? sb[p].result : 0);
            end
        end
        check("hilo_wen_h", 32'(bus.hilo_wen_h), 32'(eh));
        check("hilo_wen_l", 32'(bus.hilo_wen_l), 32'(el));
        check("hilo_wd_h", bus.hilo_wd_h, ehi);
        check("hilo_wd_l", bus.hilo_wd_l, elo);
        for (int i = 0; i < 2; i++) begin
            logic [4:0]  a;
            bit          hit;
            logic [31:0] d;
            a = drv_fwd[5*i +: 5];
            hit = 0; d = 0;
            foreach (sb[k])
                if (sb[k].regwrite && sb[k].writereg == a && a != 0) begin
                    hit = 1; d = sb[k].result;
                end
            check($sformatf("fwd_hit[%0d]", i), 32'(bus.fwd_hit[i]), 32'(hit));
            check($sformatf("fwd_data[%0d]", i), bus.fwd_data[32*i +: 32], d);
        end
        repeat (nd) void'(sb.pop_front());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) check_cycle();
        end
    end

    // Present the current group; it is taken at the first edge where the model says ready.
    task automatic issue();
        for (int t = 0; t < 64; t++) begin
            @(posedge clk); #1;
            if (model_ready) begin
                for (int l = 0; l < LANES; l++)
                    if (drv_v[l]) sb.push_back(drv_e[l]);
                drv_v = '0;
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL issue_timeout: got in_ready stuck low, expected acceptance within 64 cycles");
        drv_v = '0;
    endtask

    task automatic idle(input int n);
        drv_v = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hilo_group(input int unsigned base);
        drv_e[0] = mk(1'b0, 0, 0, 3, base, base + 1);
        drv_e[1] = mk(1'b0, 0, 0, 3, base + 2, base + 3);
        drv_v = 2'b11;
        issue();
    endtask

    task automatic random_phase(input int n);
        for (int it = 0; it < n; it++) begin
            for (int l = 0; l < LANES; l++) drv_e[l] = rand_entry();
            drv_v   = LANES'($urandom_range(0, (1 << LANES) - 1));
            drv_fwd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            issue();
        end
    endtask

    task automatic drain_all();
        for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
        check("drain_to_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) drv_e[l] = '0;
        drv_fwd = {5'd3, 5'd7};
        #2;
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_rf_wen", 32'(bus.rf_wen), 0);
        check("rst_commit_valid", 32'(bus.commit_valid), 0);
        check("rst_fwd_hit", 32'(bus.fwd_hit), 0);
        check("rst_hilo_wen", 32'({bus.hilo_wen_h, bus.hilo_wen_l}), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_ready = 1'b1;
        mon_en = 1'b1;

        drv_fwd = '0;
        drv_e[0] = mk(1, 3, 32'h11, 0, 0, 0);
        drv_e[1] = mk(1, 4, 32'h22, 0, 0, 0);
        drv_v = 2'b11; issue(); idle(3);

        drv_e[0] = mk(1, 5, 32'hA, 0, 0, 0);
        drv_e[1] = mk(1, 5, 32'hB, 0, 0, 0);
        drv_v = 2'b11; issue(); idle(3);

        drv_e[0] = mk(0, 0, 0, 3, 1, 2);
        drv_e[1] = mk(0, 0, 0, 3, 3, 4);
        drv_v = 2'b11; issue(); idle(4);

        drv_fwd = {5'd0, 5'd7};
        drv_e[0] = mk(1, 7, 32'h1, 0, 0, 0);
        drv_e[1] = mk(1, 7, 32'h2, 0, 0, 0);
        drv_v = 2'b11; issue(); idle(3);

        drv_fwd = {5'd7, 5'd0};
        drv_e[0] = mk(1, 0, 32'h5, 0, 0, 0);
        drv_e[1] = mk(1, 7, 32'h6, 0, 0, 0);
        drv_v = 2'b11; issue(); idle(3);

        // all-hilo groups outpace the one-per-cycle drain, filling past the wrap point
        for (int g = 0; g < 8; g++) hilo_group(32'h100 * (g + 1));
        drain_all();

        random_phase(400);
        drain_all();

        for (int g = 0; g < 4; g++) hilo_group(32'h900 + 16 * g);
        mon_en = 1'b0;
        check("pre_reset_count", 32'(bus.count), 5);
        #1 resetn = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count), 0);
        check("async_rst_empty", 32'(bus.empty), 1);
        check("async_rst_rf_wen", 32'(bus.rf_wen), 0);
        check("async_rst_commit", 32'(bus.commit_valid), 0);
        check("async_rst_hilo", 32'({bus.hilo_wen_h, bus.hilo_wen_l}), 0);
        check("async_rst_in_ready", 32'(bus.in_ready), 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_ready = 1'b1;
        mon_en = 1'b1;

        random_phase(100);
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, number of writeback lanes presented per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, number of buffer entries (power of two, >= 2*LANES).
REQ-003 SHALL have parameter WPORTS, default 2, number of regfile write ports drained per cycle (1..LANES).
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: resetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: in_valid  in  LANES  per-lane result valid, lane 0 oldest.
REQ-007 SHALL have ports: in_ready  out  1  queue can accept a full LANES group this cycle.
REQ-008 SHALL have ports: in_regwrite  in  LANES; in_writereg  in  5*LANES; in_result  in  32*LANES.
REQ-009 SHALL have ports: in_hilo_wen  in  2*LANES  {wen_h,wen_l} per lane; in_hi, in_lo  in  32*LANES each.
REQ-010 SHALL have ports: in_pc  in  32*LANES  instruction PC per lane.
REQ-011 SHALL have ports: rf_wen  out  WPORTS; rf_waddr  out  5*WPORTS; rf_wdata  out  32*WPORTS.
REQ-012 SHALL have ports: hilo_wen_h, hilo_wen_l  out  1 each; hilo_wd_h, hilo_wd_l  out  32 each.
REQ-013 SHALL have ports: commit_valid  out  WPORTS; commit_pc  out  32*WPORTS  retirement trace.
REQ-014 SHALL have ports: fwd_addr  in  2*5  two lookup addresses; fwd_hit  out  2; fwd_data  out  2*32.
REQ-015 SHALL have ports: count  out  $clog2(DEPTH+1)  occupied entries; empty  out  1.

Function
REQ-016 SHALL assert in_ready exactly when DEPTH-count >= LANES, using count before same-cycle dequeue.
REQ-017 SHALL, on an edge with in_ready high, enqueue every lane with in_valid set, compacted in lane order; in_valid with in_ready low SHALL be ignored (producer holds).
REQ-018 SHALL drain combinationally from the head: port p presents entry head+p; an entry enqueued at edge k is drainable no earlier than the cycle after k.
REQ-019 SHALL drain min(count, WPORTS) entries per cycle, stopping before a second entry with any hilo write in the same cycle.
REQ-020 SHALL pop drained entries at the next edge; enqueue and dequeue in one cycle SHALL both take effect.
REQ-021 SHALL assert rf_wen[p] only if the entry has regwrite and writereg != 0, and no younger entry drained the same cycle writes the same register.
REQ-022 SHALL assert commit_valid[p] for every drained entry, including no-write and reg-0 entries.
REQ-023 SHALL drive hilo_wen_h/l and hilo_wd_h/l from the single drained hilo entry; all hilo outputs 0 otherwise.
REQ-024 SHALL set fwd_hit[i] when any resident entry (draining ones included) has regwrite, writereg == fwd_addr[i], fwd_addr[i] != 0; fwd_data[i] SHALL be the youngest match, 0 on miss; incoming lanes are excluded.
REQ-025 SHALL wrap head/tail pointers modulo DEPTH; count ranges 0..DEPTH; empty = (count == 0).
REQ-026 SHALL drive all outputs to 0 on undrained ports and when empty, except in_ready.

Reset
REQ-027 SHALL, on resetn low, immediately clear pointers, count and entry valid bits regardless of clk.
REQ-028 SHALL hold during reset: rf_wen=0, hilo_wen_*=0, commit_valid=0, fwd_hit=0, count=0, empty=1, in_ready=1.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation, with no partial write.

Structure
REQ-030 SHALL define wb_entry_t (regwrite, writereg, result, hilo_wen, hi, lo, pc) in the shared mips package.
REQ-031 SHALL place the youngest-match lookup in one sub-module, writeback_fwd_cam, instantiated twice.

Verification
REQ-032 SHALL cover: LANES=2, enqueue {r3=0x11, r4=0x22} -> next cycle rf_wen=11, addrs 3/4, data 0x11/0x22, count 2->0.
REQ-033 SHALL cover: same-cycle drain r5=0xA then r5=0xB -> rf_wen=01, port1 writes r5=0xB; commit_valid=11.
REQ-034 SHALL cover: two adjacent MULT entries (hi/lo 1/2 then 3/4) -> drained on successive cycles, hilo_wd 1/2 then 3/4.
REQ-035 SHALL cover: fill to DEPTH=8 with drain blocked by hilo entries -> in_ready low at count 7; refill after wrap preserves order.
REQ-036 SHALL cover: resident r7=0x1 and r7=0x2, fwd_addr=7 -> fwd_hit=1, fwd_data=0x2; fwd_addr=0 -> fwd_hit=0.
REQ-037 SHALL cover: resetn low with count=5 -> count=0, empty=1, rf_wen=0 before next clk edge.
